// File: rtl/dcm_reset_ctrl.sv
// dcm_reset_ctrl
// Sequences the reset of the 50->25 MHz DCM wrapper, waits for lock with a
// timeout and a bounded number of retries, then releases a clean active-low
// system reset for the 25 MHz logic. Everything runs on the 50 MHz clock.
//
// Ports:
//   i_clk50         50 MHz free-running board clock
//   i_rst_n         asynchronous active-low reset
//   i_dcm_lock      DCM LOCKED output (asynchronous, synchronized internally)
//   o_dcm_reset     DCM reset, active high
//   o_sys_rst_n     system reset, active low, released only in RUN
//   o_locked_stable high in RUN
//   o_fail          sticky failure flag
//   o_retry_count   number of timed-out lock attempts (saturates at 15)
//
// Optional feature (macro DCM_LOCKLOSS_RECOVER_EN):
//   defined   - lock loss in RUN restarts the full sequence with a fresh
//               retry budget
//   undefined - lock loss in RUN is terminal (FAIL until i_rst_n)
module dcm_reset_ctrl #(
    parameter int unsigned RST_CYCLES    = 4,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned MAX_RETRIES   = 7
) (
    input  logic       i_clk50,
    input  logic       i_rst_n,
    input  logic       i_dcm_lock,
    output logic       o_dcm_reset,
    output logic       o_sys_rst_n,
    output logic       o_locked_stable,
    output logic       o_fail,
    output logic [3:0] o_retry_count
);

    localparam int unsigned RW = $clog2(RST_CYCLES + 1);
    localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);

    localparam logic [RW-1:0] RST_LAST    = RW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RESET_DCM,
        ST_WAIT_LOCK,
        ST_STABILIZE,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t        state;
    logic          lock_meta;
    logic          lock_s;
    logic [RW-1:0] rst_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [SW-1:0] stable_cnt;
    logic [3:0]    retry_next;

    always_comb begin
        retry_next = o_retry_count;
        if (o_retry_count != 4'hF) begin
            retry_next = o_retry_count + 4'd1;
        end
    end

    always_ff @(posedge i_clk50 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= ST_RESET_DCM;
            lock_meta       <= 1'b0;
            lock_s          <= 1'b0;
            rst_cnt         <= '0;
            tmo_cnt         <= '0;
            stable_cnt      <= '0;
            o_dcm_reset     <= 1'b1;
            o_sys_rst_n     <= 1'b0;
            o_locked_stable <= 1'b0;
            o_fail          <= 1'b0;
            o_retry_count   <= '0;
        end else begin
            lock_meta <= i_dcm_lock;
            lock_s    <= lock_meta;

            case (state)
                ST_RESET_DCM: begin
                    // o_dcm_reset was set on entry; this counts its high time
                    if (rst_cnt == RST_LAST) begin
                        state       <= ST_WAIT_LOCK;
                        rst_cnt     <= '0;
                        tmo_cnt     <= '0;
                        o_dcm_reset <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt + RW'(1);
                    end
                end

                ST_WAIT_LOCK: begin
                    // lock wins over a timeout expiring in the same cycle
                    if (lock_s) begin
                        state      <= ST_STABILIZE;
                        stable_cnt <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        o_retry_count <= retry_next;
                        o_dcm_reset   <= 1'b1;
                        rst_cnt       <= '0;
                        if (retry_next >= RETRY_LIMIT) begin
                            state  <= ST_FAIL;
                            o_fail <= 1'b1;
                        end else begin
                            state <= ST_RESET_DCM;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                ST_STABILIZE: begin
                    if (!lock_s) begin
                        state      <= ST_WAIT_LOCK;
                        tmo_cnt    <= '0;
                        stable_cnt <= '0;
                    end else if (stable_cnt == STABLE_LAST) begin
                        state           <= ST_RUN;
                        o_sys_rst_n     <= 1'b1;
                        o_locked_stable <= 1'b1;
                    end else begin
                        stable_cnt <= stable_cnt + SW'(1);
                    end
                end

                ST_RUN: begin
                    if (!lock_s) begin
                        o_sys_rst_n     <= 1'b0;
                        o_locked_stable <= 1'b0;
                        o_dcm_reset     <= 1'b1;
                        rst_cnt         <= '0;
`ifdef DCM_LOCKLOSS_RECOVER_EN
                        state         <= ST_RESET_DCM;
                        o_retry_count <= '0;
`else
                        state  <= ST_FAIL;
                        o_fail <= 1'b1;
`endif
                    end
                end

                ST_FAIL: begin
                    state <= ST_FAIL;
                end

                default: begin
                    state <= ST_RESET_DCM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcm_reset_ctrl.sv
// tb_dcm_reset_ctrl
// Directed scoreboard bench for dcm_reset_ctrl. The stimulus process pushes
// every expected change of the output tuple
// {o_dcm_reset, o_sys_rst_n, o_locked_stable, o_fail, o_retry_count} together
// with the clock edge at which it must appear; the monitor pops and compares
// whenever the tuple changes. Leftover expectations count as failures.
module tb_dcm_reset_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lock = 1'b0;
    logic       dcm_reset;
    logic       sys_rst_n;
    logic       locked_stable;
    logic       fail;
    logic [3:0] retry_count;

    int unsigned cyc = 0;
    int unsigned tests = 0;
    int unsigned fails = 0;
    bit          done = 1'b0;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  val;
        string       name;
    } exp_t;

    exp_t q[$];

    dcm_reset_ctrl #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (16),
        .MAX_RETRIES   (3)
    ) dut (
        .i_clk50         (clk),
        .i_rst_n         (rst_n),
        .i_dcm_lock      (lock),
        .o_dcm_reset     (dcm_reset),
        .o_sys_rst_n     (sys_rst_n),
        .o_locked_stable (locked_stable),
        .o_fail          (fail),
        .o_retry_count   (retry_count)
    );

    initial forever #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input int unsigned c, input logic [7:0] v, input string n);
        exp_t e;
        e.cyc  = c;
        e.val  = v;
        e.name = n;
        q.push_back(e);
    endfunction

    task automatic wait_cyc(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    // Assert reset shortly after a rising edge; the outputs must reach reset
    // values before the following falling edge.
    task automatic assert_rst(input string n);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        push(cyc, 8'b1000_0000, n);
    endtask

    task automatic release_rst(output int unsigned r);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
    endtask

    // Stimulus
    initial begin
        int unsigned r;
        int unsigned c;
        repeat (3) @(negedge clk);

        // A: normal lock at cycle 10 after release
        release_rst(r);
        push(r + 4,  8'b0000_0000, "A_dcm_release");
        wait_cyc(r + 10);
        lock = 1'b1;
        push(r + 29, 8'b0110_0000, "A_run");
        wait_cyc(r + 40);

        // B: lock loss in RUN
        c = cyc;
        lock = 1'b0;
`ifdef DCM_LOCKLOSS_RECOVER_EN
        push(c + 3,  8'b1000_0000, "B_loss_restart");
        push(c + 7,  8'b0000_0000, "B_pulse_end");
        wait_cyc(c + 10);
        lock = 1'b1;
        push(c + 29, 8'b0110_0000, "B_rerun");
        wait_cyc(c + 40);
`else
        push(c + 3,  8'b1001_0000, "B_loss_fail");
        wait_cyc(c + 10);
`endif

        // C: reset from FAIL/RUN, then timeouts until FAIL
        assert_rst("C_rst");
        lock = 1'b0;
        release_rst(r);
        push(r + 4,  8'b0000_0000, "C_pulse0_end");
        push(r + 24, 8'b1000_0001, "C_retry1");
        push(r + 28, 8'b0000_0001, "C_pulse1_end");
        push(r + 48, 8'b1000_0010, "C_retry2");
        push(r + 52, 8'b0000_0010, "C_pulse2_end");
        push(r + 72, 8'b1001_0011, "C_fail");
        wait_cyc(r + 80);

        // D: reset during FAIL
        assert_rst("D_rst_fail");
        release_rst(r);

        // E: one-cycle lock glitch at stable count 10
        push(r + 4,  8'b0000_0000, "E_dcm_release");
        wait_cyc(r + 10);
        lock = 1'b1;
        wait_cyc(r + 21);
        lock = 1'b0;
        wait_cyc(r + 22);
        lock = 1'b1;
        push(r + 41, 8'b0110_0000, "E_run_after_glitch");
        wait_cyc(r + 50);

        // F: reset in RUN, then reset during STABILIZE, clean restart
        assert_rst("F_rst_run");
        release_rst(r);
        push(r + 4,  8'b0000_0000, "F_dcm_release");
        wait_cyc(r + 9);
        assert_rst("F_rst_stabilize");
        release_rst(r);
        push(r + 4,  8'b0000_0000, "F_dcm_release2");
        push(r + 21, 8'b0110_0000, "F_restart_run");
        wait_cyc(r + 30);

        // G: lock arrives in the cycle the timeout expires
        assert_rst("G_rst");
        lock = 1'b0;
        release_rst(r);
        push(r + 4,  8'b0000_0000, "G_dcm_release");
        wait_cyc(r + 21);
        lock = 1'b1;
        push(r + 40, 8'b0110_0000, "G_lock_beats_timeout");
        wait_cyc(r + 50);

        done = 1'b1;
    end

    // Monitor
    initial begin
        logic [7:0] cur;
        logic [7:0] last;
        exp_t       e;

        @(negedge clk);
        cur = {dcm_reset, sys_rst_n, locked_stable, fail, retry_count};
        tests++;
        if (cur !== 8'b1000_0000) begin
            fails++;
            $display("FAIL reset_state: got=%b want=%b", cur, 8'b1000_0000);
        end
        last = 8'b1000_0000;

        while (!done && cyc < 5000) begin
            @(negedge clk);
            cur = {dcm_reset, sys_rst_n, locked_stable, fail, retry_count};
            if (cur !== last) begin
                last = cur;
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_change: cyc=%0d got=%b", cyc, cur);
                end else begin
                    e = q.pop_front();
                    if (cur !== e.val || cyc != e.cyc) begin
                        fails++;
                        $display("FAIL %s: got=%b at cyc %0d, want=%b at cyc %0d",
                                 e.name, cur, cyc, e.val, e.cyc);
                    end
                end
            end
        end

        if (!done) begin
            tests++;
            fails++;
            $display("FAIL watchdog: stimulus did not finish by cyc %0d", cyc);
        end

        while (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            fails++;
            $display("FAIL %s: no change seen, want=%b at cyc %0d", e.name, e.val, e.cyc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
